// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end feeding the IF/ID register.
//   Generates word-aligned fetch PCs, performs one-outstanding req/ack
//   fetches against instruction memory, buffers {instr, pc+4} in a
//   fall-through prefetch FIFO and hands entries to decode under id_stall.
//   A redirect flushes the FIFO and squashes any in-flight fetch.
// Ports:
//   clk          clock, all state on posedge
//   reset        asynchronous, active-low reset
//   imem_req     fetch request valid
//   imem_addr    fetch address (always the current fetch PC)
//   imem_ack     fetch complete, imem_rdata valid this cycle
//   imem_rdata   fetched instruction
//   redirect     taken branch/jump pulse
//   redirect_pc  new fetch address (low two bits ignored)
//   id_stall     decode cannot accept this cycle
//   if_valid     FIFO head valid
//   if_instr     FIFO head instruction, 0 when empty
//   if_pc4       FIFO head PC+4, 0 when empty
//   fetch_count  instructions delivered to decode (wraps)
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic [31:0] fetch_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] fetch_pc, fetch_pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_aligned;
  logic [AW:0] count, count_next;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic        push, pop;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc4_mem   [DEPTH];

  assign pc_plus4         = fetch_pc + 32'd4;
  assign redirect_aligned = redirect_pc & ~32'h3;
  assign imem_addr        = fetch_pc;
  assign if_valid         = (count != '0);
  assign if_instr         = if_valid ? instr_mem[rd_ptr] : '0;
  assign if_pc4           = if_valid ? pc4_mem[rd_ptr]   : '0;

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    push          = 1'b0;
    count_next    = count;
    imem_req      = (state == REQ);
    pop           = if_valid && !id_stall && !redirect;

    case (state)
      IDLE: begin
        if (redirect) begin
          fetch_pc_next = redirect_aligned;
        end else if (count < DEPTH_C) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_next = redirect_aligned;
          state_next    = imem_ack ? IDLE : DRAIN;
        end else if (imem_ack) begin
          push          = 1'b1;
          fetch_pc_next = pc_plus4;
        end
      end
      DRAIN: begin
        // The squashed fetch must still complete before a new one may issue.
        if (redirect) fetch_pc_next = redirect_aligned;
        if (imem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (redirect) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + ONE_C;
        2'b01:   count_next = count - ONE_C;
        default: count_next = count;
      endcase
    end

    // Back-to-back requests continue only while the post-update FIFO has room.
    if (push && (count_next >= DEPTH_C)) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fetch_count <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      count    <= count_next;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      if (pop) fetch_count <= fetch_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc4_mem[wr_ptr]   <= pc_plus4;
    end
  end

endmodule
